// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared PS/2 key event types and constants for the keyboard path
package kbd_pkg;

    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_ENTER  = 8'h5A;
    localparam logic [7:0] PS2_SPACE  = 8'h29;
    localparam logic [7:0] PS2_ESC    = 8'h76;

    // Same bit layout as hps_io ps2_key: [10] toggle, [9] pressed, [8] ext, [7:0] code
    typedef struct packed {
        logic       tog;
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    // Result of the ASCII lookup
    typedef struct packed {
        logic       valid;
        logic [7:0] code;
        logic       shift;
    } key_map_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SH_DN,
        ST_GAP1,
        ST_K_DN,
        ST_HOLD,
        ST_K_UP,
        ST_GAP2,
        ST_SH_UP,
        ST_GAP3
    } inj_state_e;

endpackage

// File: rtl/ascii_to_ps2.sv
// rtl/ascii_to_ps2.sv - ASCII byte to PC-layout set-2 make code with shift flag
module ascii_to_ps2
    import kbd_pkg::*;
(
    input  logic [7:0] ascii,
    output key_map_t   map
);

    function automatic logic [7:0] letter_code(input logic [7:0] c);
        logic [7:0] r;
        case (c)
            "a": r = 8'h1C;  "b": r = 8'h32;  "c": r = 8'h21;  "d": r = 8'h23;
            "e": r = 8'h24;  "f": r = 8'h2B;  "g": r = 8'h34;  "h": r = 8'h33;
            "i": r = 8'h43;  "j": r = 8'h3B;  "k": r = 8'h42;  "l": r = 8'h4B;
            "m": r = 8'h3A;  "n": r = 8'h31;  "o": r = 8'h44;  "p": r = 8'h4D;
            "q": r = 8'h15;  "r": r = 8'h2D;  "s": r = 8'h1B;  "t": r = 8'h2C;
            "u": r = 8'h3C;  "v": r = 8'h2A;  "w": r = 8'h1D;  "x": r = 8'h22;
            "y": r = 8'h35;  "z": r = 8'h1A;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Pure case table; upper case reuses the letter code with shift set
    always_comb begin
        map = '0;
        if (ascii >= "a" && ascii <= "z") begin
            map = '{1'b1, letter_code(ascii), 1'b0};
        end else if (ascii >= "A" && ascii <= "Z") begin
            map = '{1'b1, letter_code(ascii | 8'h20), 1'b1};
        end else begin
            case (ascii)
                "1":   map = '{1'b1, 8'h16, 1'b0};
                "!":   map = '{1'b1, 8'h16, 1'b1};
                "2":   map = '{1'b1, 8'h1E, 1'b0};
                "@":   map = '{1'b1, 8'h1E, 1'b1};
                "3":   map = '{1'b1, 8'h26, 1'b0};
                "#":   map = '{1'b1, 8'h26, 1'b1};
                "4":   map = '{1'b1, 8'h25, 1'b0};
                "$":   map = '{1'b1, 8'h25, 1'b1};
                "5":   map = '{1'b1, 8'h2E, 1'b0};
                "%":   map = '{1'b1, 8'h2E, 1'b1};
                "6":   map = '{1'b1, 8'h36, 1'b0};
                "7":   map = '{1'b1, 8'h3D, 1'b0};
                "&":   map = '{1'b1, 8'h3D, 1'b1};
                "8":   map = '{1'b1, 8'h3E, 1'b0};
                "*":   map = '{1'b1, 8'h3E, 1'b1};
                "9":   map = '{1'b1, 8'h46, 1'b0};
                "(":   map = '{1'b1, 8'h46, 1'b1};
                "0":   map = '{1'b1, 8'h45, 1'b0};
                ")":   map = '{1'b1, 8'h45, 1'b1};
                "-":   map = '{1'b1, 8'h4E, 1'b0};
                "=":   map = '{1'b1, 8'h55, 1'b0};
                "+":   map = '{1'b1, 8'h55, 1'b1};
                ";":   map = '{1'b1, 8'h4C, 1'b0};
                ":":   map = '{1'b1, 8'h4C, 1'b1};
                "'":   map = '{1'b1, 8'h52, 1'b0};
                "\"":  map = '{1'b1, 8'h52, 1'b1};
                ",":   map = '{1'b1, 8'h41, 1'b0};
                ".":   map = '{1'b1, 8'h49, 1'b0};
                "/":   map = '{1'b1, 8'h4A, 1'b0};
                "?":   map = '{1'b1, 8'h4A, 1'b1};
                8'h0D: map = '{1'b1, PS2_ENTER, 1'b0};
                8'h0A: map = '{1'b1, PS2_ENTER, 1'b0};
                8'h20: map = '{1'b1, PS2_SPACE, 1'b0};
                8'h1B: map = '{1'b1, PS2_ESC, 1'b0};
                default: map = '0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_injector.sv
// rtl/ps2_key_injector.sv - merges live PS/2 events with timed injected ASCII keystrokes
module ps2_key_injector
    import kbd_pkg::*;
#(
    parameter int HOLD_CYCLES = 1_000_000,
    parameter int GAP_CYCLES  = 500_000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key_in,
    output logic [10:0] ps2_key_out,
    input  logic        inj_valid,
    input  logic [7:0]  inj_data,
    output logic        inj_ready,
    output logic        inj_busy,
    output logic        inj_err
);

    localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
    localparam logic [TW-1:0] HOLD_T = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] GAP_T  = TW'(GAP_CYCLES);

    ps2_evt_t   out_q;
    logic       live_tog_q;
    inj_state_e state_q, state_d, act_state;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0] code_q;
    logic       shift_q;
    logic       ready_q, busy_q, err_q;

    key_map_t   map;
    logic       live_fire, accept, timer_done;
    logic       emit_req, emit_go, emit_press;
    logic [7:0] emit_code;
    inj_state_e emit_next;
    logic [TW-1:0] emit_load;

    ascii_to_ps2 u_map (
        .ascii (inj_data),
        .map   (map)
    );

    assign live_fire  = ps2_key_in[10] ^ live_tog_q;
    assign accept     = inj_valid & ready_q;
    // Timer counts emit-to-emit: a wait state lasts its loaded value, at least one cycle
    assign timer_done = (timer_q <= TW'(1));

    // Resolve where the FSM effectively is this cycle, and what (if anything) it wants to emit.
    // A finishing wait state hands straight to its emit state so the emit lands on the exit edge.
    always_comb begin
        act_state = state_q;
        case (state_q)
            ST_GAP1: if (timer_done) act_state = ST_K_DN;
            ST_HOLD: if (timer_done) act_state = ST_K_UP;
            ST_GAP2: if (timer_done) act_state = shift_q ? ST_SH_UP : ST_IDLE;
            ST_GAP3: if (timer_done) act_state = ST_IDLE;
            default: act_state = state_q;
        endcase

        emit_req   = 1'b0;
        emit_code  = code_q;
        emit_press = 1'b0;
        emit_next  = act_state;
        emit_load  = GAP_T;
        case (act_state)
            ST_SH_DN: begin
                emit_req = 1'b1; emit_code = PS2_LSHIFT; emit_press = 1'b1;
                emit_next = ST_GAP1; emit_load = GAP_T;
            end
            ST_K_DN: begin
                emit_req = 1'b1; emit_code = code_q; emit_press = 1'b1;
                emit_next = ST_HOLD; emit_load = HOLD_T;
            end
            ST_K_UP: begin
                emit_req = 1'b1; emit_code = code_q; emit_press = 1'b0;
                emit_next = ST_GAP2; emit_load = GAP_T;
            end
            ST_SH_UP: begin
                emit_req = 1'b1; emit_code = PS2_LSHIFT; emit_press = 1'b0;
                emit_next = ST_GAP3; emit_load = GAP_T;
            end
            default: emit_req = 1'b0;
        endcase

        // Live traffic owns the output this cycle; the injected emit simply retries next cycle
        emit_go = emit_req & ~live_fire;
    end

    // Next state and timer value
    always_comb begin
        state_d = act_state;
        timer_d = timer_q;
        if (emit_go) begin
            state_d = emit_next;
            timer_d = emit_load;
        end else if (act_state == ST_IDLE && accept) begin
            if (map.valid) state_d = map.shift ? ST_SH_DN : ST_K_DN;
            else           state_d = ST_IDLE;
        end else if (!timer_done) begin
            timer_d = timer_q - TW'(1);
        end
    end

    // FSM, timer, output merge register and registered handshake outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            out_q      <= '0;
            live_tog_q <= ps2_key_in[10];
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            code_q     <= '0;
            shift_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            live_tog_q <= ps2_key_in[10];
            if (live_fire) begin
                out_q <= '{tog: ~out_q.tog, pressed: ps2_key_in[9], ext: ps2_key_in[8],
                           code: ps2_key_in[7:0]};
            end else if (emit_go) begin
                out_q <= '{tog: ~out_q.tog, pressed: emit_press, ext: 1'b0, code: emit_code};
            end
            if (accept && map.valid) begin
                code_q  <= map.code;
                shift_q <= map.shift;
            end
            state_q <= state_d;
            timer_q <= timer_d;
            ready_q <= (state_d == ST_IDLE);
            busy_q  <= (state_d != ST_IDLE);
            err_q   <= accept & ~map.valid;
        end
    end

    assign ps2_key_out = out_q;
    assign inj_ready   = ready_q;
    assign inj_busy    = busy_q;
    assign inj_err     = err_q;

endmodule

// File: tb/tb_ps2_key_injector.sv
// tb/tb_ps2_key_injector.sv - scoreboard bench for ps2_key_injector
module tb_ps2_key_injector;

    localparam int HOLD = 8;
    localparam int GAP  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key_in = '0;
    logic [10:0] ps2_key_out;
    logic        inj_valid = 1'b0;
    logic [7:0]  inj_data = '0;
    logic        inj_ready, inj_busy, inj_err;

    ps2_key_injector #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk_sys     (clk),
        .reset       (reset),
        .ps2_key_in  (ps2_key_in),
        .ps2_key_out (ps2_key_out),
        .inj_valid   (inj_valid),
        .inj_data    (inj_data),
        .inj_ready   (inj_ready),
        .inj_busy    (inj_busy),
        .inj_err     (inj_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] code;
        logic       press;
        logic       ext;
        int         at;
    } ev_t;
    ev_t exp_q[$];

    // Reference keyboard: each key has an unshifted char, a shifted char ('~' = none) and a code
    string lower_keys = "abcdefghijklmnopqrstuvwxyz1234567890-=;',./";
    string upper_keys = "ABCDEFGHIJKLMNOPQRSTUVWXYZ!@#$%~&*()~+:\"~~?";
    logic [7:0] key_codes [43] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
        8'h4E, 8'h55, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic void model_map(input logic [7:0] b, output logic v,
                                      output logic [7:0] c, output logic sh);
        v = 1'b0; c = 8'h00; sh = 1'b0;
        for (int i = 0; i < lower_keys.len(); i++) begin
            if (lower_keys[i] == b) begin v = 1'b1; c = key_codes[i]; sh = 1'b0; end
            if (b != 8'h7E && upper_keys[i] == b) begin v = 1'b1; c = key_codes[i]; sh = 1'b1; end
        end
        if (b == 8'h0D || b == 8'h0A) begin v = 1'b1; c = 8'h5A; end
        if (b == 8'h20) begin v = 1'b1; c = 8'h29; end
        if (b == 8'h1B) begin v = 1'b1; c = 8'h76; end
    endfunction

    function automatic void push_ev(input logic [7:0] code, input logic press,
                                    input logic ext, input int at);
        ev_t e;
        e.code = code; e.press = press; e.ext = ext; e.at = at;
        exp_q.push_back(e);
    endfunction

    // Monitor: every output toggle must match the head of the expected queue
    logic prev_tog = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_tog = ps2_key_out[10];
        end else if (ps2_key_out[10] != prev_tog) begin
            prev_tog = ps2_key_out[10];
            if (exp_q.size() == 0) begin
                check("unexpected_event", {21'd0, ps2_key_out}, 32'hFFFFFFFF);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_fields", {22'd0, ps2_key_out[9:0]}, {22'd0, e.press, e.ext, e.code});
                check("event_cycle", cyc, e.at);
            end
        end
    end

    // Drive a live event; it must appear on the next edge
    task automatic live(input logic [7:0] code, input logic press, input logic ext);
        ps2_key_in = {~ps2_key_in[10], press, ext, code};
        push_ev(code, press, ext, cyc + 1);
    endtask

    task automatic send(input logic [7:0] b, output int acc);
        int k;
        for (k = 0; k < 100 && !inj_ready; k++) @(negedge clk);
        check("ready_wait", inj_ready, 1);
        inj_valid = 1'b1;
        inj_data  = b;
        acc = cyc + 1;
        @(negedge clk);
        inj_valid = 1'b0;
    endtask

    // Push the event sequence a character should produce, starting stall cycles late
    task automatic expect_char(input logic [7:0] c, input logic sh, input int acc,
                               input int stall, output int busy_end);
        int t;
        t = acc + 1 + stall;
        if (sh) begin push_ev(8'h12, 1'b1, 1'b0, t); t += GAP; end
        push_ev(c, 1'b1, 1'b0, t);
        t += HOLD;
        push_ev(c, 1'b0, 1'b0, t);
        if (sh) begin t += GAP; push_ev(8'h12, 1'b0, 1'b0, t); end
        busy_end = t + GAP;
    endtask

    task automatic run_char(input logic [7:0] b, input int stall);
        int acc, busy_end, k;
        logic v, sh;
        logic [7:0] c;
        send(b, acc);
        if (stall != 0) live(8'h33, 1'b1, 1'b1);
        model_map(b, v, c, sh);
        if (v) begin
            expect_char(c, sh, acc, stall, busy_end);
            check("err_valid", inj_err, 0);
            check("busy_on_accept", inj_busy, 1);
            for (k = 0; k < 200 && inj_busy; k++) @(negedge clk);
            check("busy_end_cycle", cyc, busy_end);
            check("ready_after_char", inj_ready, 1);
        end else begin
            check("err_pulse", inj_err, 1);
            check("busy_invalid", inj_busy, 0);
            check("ready_invalid", inj_ready, 1);
            @(negedge clk);
            check("err_one_cycle", inj_err, 0);
            check("ready_stays", inj_ready, 1);
        end
    endtask

    logic [7:0] dir_bytes [10] = '{8'h0D, 8'h0A, 8'h20, 8'h1B, 8'h22, 8'h3F,
                                   8'h4C, 8'h4C, 8'h36, 8'h5E};

    initial begin
        int acc;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out", ps2_key_out, 0);
        check("rst_ready", inj_ready, 0);
        check("rst_busy", inj_busy, 0);
        check("rst_err", inj_err, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", inj_ready, 1);
        check("out_after_rst", ps2_key_out, 0);

        // Live forwarding
        live(8'h1C, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Single lower-case, shifted, collision with live, invalid
        run_char(8'h61, 0);
        run_char(8'h41, 0);
        run_char(8'h61, 1);
        run_char(8'h7F, 0);

        // Special keys, shifted punctuation, repeated char, unmapped
        for (int i = 0; i < 10; i++) run_char(dir_bytes[i], 0);

        // Random mix of live events and injected bytes
        for (int i = 0; i < 24; i++) begin
            int pick;
            logic [7:0] b;
            pick = $urandom_range(0, 3);
            if (pick == 0) begin
                live(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                repeat (2) @(negedge clk);
            end else begin
                if (pick == 1) b = 8'($urandom_range(0, 127));
                else if (pick == 2) b = lower_keys[$urandom_range(0, 42)];
                else b = upper_keys[$urandom_range(0, 42)];
                run_char(b, 0);
            end
        end

        // Reset during HOLD: no release may follow
        send(8'h61, acc);
        push_ev(8'h1C, 1'b1, 1'b0, acc + 1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_out", ps2_key_out, 0);
        check("midrst_ready", inj_ready, 0);
        check("midrst_busy", inj_busy, 0);
        reset = 1'b0;
        @(negedge clk);
        check("postrst_ready", inj_ready, 1);
        check("postrst_busy", inj_busy, 0);
        check("postrst_out", ps2_key_out, 0);
        repeat (20) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
